// File: rtl/sid_osc_bank.sv
// N-voice SID oscillator bank: phase accumulators, noise LFSRs, waveform generators and mixers.
// Latency: phase update on clkEn edge k -> waveform register at k+1 -> oVoices at k+2; oOsc3 on clkEn.
// Backpressure: none; register writes and clkEn ticks are accepted unconditionally every cycle.
module sid_osc_bank #(
  parameter int NUM_VOICES  = 3,
  parameter int ACC_WIDTH   = 24,
  parameter int NOISE_TAP   = 19,
  parameter int BASE_ADDR   = 0,
  parameter int COMBINE_AND = 0
) (
  input  logic                    clk,
  input  logic                    iRst,
  input  logic                    clkEn,
  input  logic                    iWE,
  input  logic [4:0]              iAddr,
  input  logic [7:0]              iData,
  output logic [NUM_VOICES-1:0]   oMSB,
  output logic [12*NUM_VOICES-1:0] oVoices,
  output logic [7:0]              oOsc3
);

  localparam logic [22:0] LFSR_SEED = 23'h7FFFFF;

  for (genvar i = 0; i < NUM_VOICES; i++) begin : gVoice
    // Sync/ring source is the previous voice, wrapping so voice 0 follows the last one
    localparam int SRC = (i == 0) ? NUM_VOICES - 1 : i - 1;
    localparam logic [4:0] ADDR_FLO = 5'(BASE_ADDR + 7*i + 0);
    localparam logic [4:0] ADDR_FHI = 5'(BASE_ADDR + 7*i + 1);
    localparam logic [4:0] ADDR_PLO = 5'(BASE_ADDR + 7*i + 2);
    localparam logic [4:0] ADDR_PHI = 5'(BASE_ADDR + 7*i + 3);
    localparam logic [4:0] ADDR_CTL = 5'(BASE_ADDR + 7*i + 4);

    logic [15:0]          freq;
    logic [11:0]          pw;
    logic                 noiseEn, pulseEn, sawEn, triEn, testBit, ringBit, syncBit;
    logic [ACC_WIDTH-1:0] phase;
    logic                 srcLag, tapLag, testLag;
    logic [22:0]          lfsr;
    logic [11:0]          sawW, triW, pulseW, noiseW, mix, mixNext;
    logic [11:0]          top;
    logic                 srcMsb;

    assign srcMsb  = oMSB[SRC];
    assign oMSB[i] = phase[ACC_WIDTH-1];
    assign top     = phase[ACC_WIDTH-1 -: 12];
    assign oVoices[12*i +: 12] = mix;

    // Voice register file, written from the bus decoder
    always_ff @(posedge clk) begin
      if (iRst) begin
        freq <= '0;
        pw   <= '0;
        {noiseEn, pulseEn, sawEn, triEn, testBit, ringBit, syncBit} <= '0;
      end else if (iWE) begin
        if (iAddr == ADDR_FLO) freq[7:0]  <= iData;
        if (iAddr == ADDR_FHI) freq[15:8] <= iData;
        if (iAddr == ADDR_PLO) pw[7:0]    <= iData;
        if (iAddr == ADDR_PHI) pw[11:8]   <= iData[3:0];
        if (iAddr == ADDR_CTL)
          {noiseEn, pulseEn, sawEn, triEn, testBit, ringBit, syncBit} <= iData[7:1];
      end
    end

    // Phase accumulator with test/hard-sync reset and the noise LFSR, advanced on each tick
    always_ff @(posedge clk) begin
      if (iRst) begin
        phase   <= '0;
        srcLag  <= 1'b0;
        tapLag  <= 1'b0;
        testLag <= 1'b0;
        lfsr    <= LFSR_SEED;
      end else if (clkEn) begin
        srcLag  <= srcMsb;
        tapLag  <= phase[NOISE_TAP];
        testLag <= testBit;
        if (testBit)
          phase <= '0;
        else if (syncBit && srcMsb && !srcLag)
          phase <= '0;
        else
          phase <= phase + ACC_WIDTH'(freq);
        // Holding during test and reseeding on release also pulls a stuck all-zero LFSR out
        if (testBit || testLag)
          lfsr <= LFSR_SEED;
        else if (phase[NOISE_TAP] && !tapLag)
          lfsr <= {lfsr[21:0], lfsr[22] ^ lfsr[17]};
      end
    end

    // Waveform generators, one register stage after the accumulator
    always_ff @(posedge clk) begin
      if (iRst) begin
        sawW   <= '0;
        pulseW <= '0;
        triW   <= '0;
        noiseW <= '0;
      end else begin
        sawW   <= top;
        pulseW <= (top >= pw) ? 12'hFFF : 12'h000;
        triW   <= (phase[ACC_WIDTH-1] ^ (ringBit & srcMsb)) ? ~phase[ACC_WIDTH-2 -: 12]
                                                            :  phase[ACC_WIDTH-2 -: 12];
        noiseW <= {lfsr[20], lfsr[18], lfsr[14], lfsr[11], lfsr[9], lfsr[5], lfsr[2], lfsr[0], 4'b0000};
      end
    end

    // Combine enabled waveforms; AND mode starts from all-ones, silence forces zero
    always_comb begin
      mixNext = (COMBINE_AND != 0) ? 12'hFFF : 12'h000;
      if (triEn)   mixNext = (COMBINE_AND != 0) ? (mixNext & triW)   : (mixNext ^ triW);
      if (sawEn)   mixNext = (COMBINE_AND != 0) ? (mixNext & sawW)   : (mixNext ^ sawW);
      if (pulseEn) mixNext = (COMBINE_AND != 0) ? (mixNext & pulseW) : (mixNext ^ pulseW);
      if (noiseEn) mixNext = (COMBINE_AND != 0) ? (mixNext & noiseW) : (mixNext ^ noiseW);
      if (!(triEn || sawEn || pulseEn || noiseEn)) mixNext = 12'h000;
    end

    // Mixer output register
    always_ff @(posedge clk) begin
      if (iRst) mix <= '0;
      else      mix <= mixNext;
    end
  end

  // OSC3 readback: snapshot of the last voice's upper mix bits once per tick
  always_ff @(posedge clk) begin
    if (iRst)       oOsc3 <= '0;
    else if (clkEn) oOsc3 <= oVoices[12*NUM_VOICES-1 -: 8];
  end

endmodule
